// File: rtl/axil_user_regfile.sv
// AXI-Lite user register file: six R/W registers, a write-commit counter
// and a read-accept counter. AW and W land in independent one-entry slots
// and commit together; reads go through a two-state IDLE/RESP FSM.
module axil_user_regfile #(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32
) (
  input  logic                     ALCLK,
  input  logic                     ARESET,
  input  logic [pADDR_WIDTH-1:0]   awaddr,
  input  logic                     awvalid,
  output logic                     awready,
  input  logic [pDATA_WIDTH-1:0]   wdata,
  input  logic [pDATA_WIDTH/8-1:0] wstrb,
  input  logic                     wvalid,
  output logic                     wready,
  input  logic [pADDR_WIDTH-1:0]   araddr,
  input  logic                     arvalid,
  output logic                     arready,
  output logic [pDATA_WIDTH-1:0]   rdata,
  output logic                     rvalid,
  input  logic                     rready,
  output logic [pDATA_WIDTH-1:0]   cfg_out
);

  localparam int STRB_W = pDATA_WIDTH / 8;
  localparam int NUM_RW = 6;
  localparam logic [pDATA_WIDTH-1:0] ONE = {{(pDATA_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic {RD_IDLE, RD_RESP} rd_state_e;

  // write slots: only the decoded index and an out-of-range flag are kept
  logic                   aw_full_q, aw_full_d;
  logic [2:0]             aw_idx_q, aw_idx_d;
  logic                   aw_oor_q, aw_oor_d;
  logic                   w_full_q, w_full_d;
  logic [pDATA_WIDTH-1:0] w_data_q, w_data_d;
  logic [STRB_W-1:0]      w_strb_q, w_strb_d;

  logic [pDATA_WIDTH-1:0] regs_q [NUM_RW];
  logic [pDATA_WIDTH-1:0] regs_d [NUM_RW];
  logic [pDATA_WIDTH-1:0] wr_cnt_q, wr_cnt_d;
  logic [pDATA_WIDTH-1:0] rd_cnt_q, rd_cnt_d;

  rd_state_e              rd_state_q, rd_state_d;
  logic [pDATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [pDATA_WIDTH-1:0] rd_val;
  logic                   commit;

  // byte offsets within a word carry no meaning here
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{awaddr[1:0], araddr[1:0]};

  assign commit  = aw_full_q & w_full_q;
  assign awready = ~aw_full_q;
  assign wready  = ~w_full_q;
  assign rdata   = rdata_q;
  assign cfg_out = regs_q[0];

  // slot loading and commit of a buffered write into the register array
  always_comb begin
    aw_full_d = aw_full_q;
    aw_idx_d  = aw_idx_q;
    aw_oor_d  = aw_oor_q;
    w_full_d  = w_full_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    regs_d    = regs_q;
    wr_cnt_d  = wr_cnt_q;
    if (commit) begin
      aw_full_d = 1'b0;
      w_full_d  = 1'b0;
      wr_cnt_d  = wr_cnt_q + ONE;
      for (int r = 0; r < NUM_RW; r++) begin
        if (!aw_oor_q && aw_idx_q == 3'(r)) begin
          for (int b = 0; b < STRB_W; b++) begin
            if (w_strb_q[b]) regs_d[r][b*8 +: 8] = w_data_q[b*8 +: 8];
          end
        end
      end
    end
    // a full slot never accepts, so loading cannot collide with commit
    if (awvalid && !aw_full_q) begin
      aw_full_d = 1'b1;
      aw_idx_d  = awaddr[4:2];
      aw_oor_d  = |awaddr[pADDR_WIDTH-1:5];
    end
    if (wvalid && !w_full_q) begin
      w_full_d = 1'b1;
      w_data_d = wdata;
      w_strb_d = wstrb;
    end
  end

  // read mux over current (pre-commit) contents; out-of-range reads as zero
  always_comb begin
    rd_val = '0;
    if (~|araddr[pADDR_WIDTH-1:5]) begin
      for (int r = 0; r < NUM_RW; r++) begin
        if (araddr[4:2] == 3'(r)) rd_val = regs_q[r];
      end
      if (araddr[4:2] == 3'd6) rd_val = wr_cnt_q;
      if (araddr[4:2] == 3'd7) rd_val = rd_cnt_q;
    end
  end

  // read FSM next state, response capture and read-accept counting
  always_comb begin
    rd_state_d = rd_state_q;
    rdata_d    = rdata_q;
    rd_cnt_d   = rd_cnt_q;
    arready    = 1'b0;
    rvalid     = 1'b0;
    case (rd_state_q)
      RD_IDLE: begin
        arready = 1'b1;
        if (arvalid) begin
          rdata_d    = rd_val;
          rd_cnt_d   = rd_cnt_q + ONE;
          rd_state_d = RD_RESP;
        end
      end
      RD_RESP: begin
        rvalid = 1'b1;
        if (rready) rd_state_d = RD_IDLE;
      end
      default: rd_state_d = RD_IDLE;
    endcase
  end

  // write-side state: slots, registers, commit counter
  always_ff @(posedge ALCLK) begin
    if (ARESET) begin
      aw_full_q <= 1'b0;
      aw_idx_q  <= '0;
      aw_oor_q  <= 1'b0;
      w_full_q  <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      wr_cnt_q  <= '0;
      for (int r = 0; r < NUM_RW; r++) regs_q[r] <= '0;
    end else begin
      aw_full_q <= aw_full_d;
      aw_idx_q  <= aw_idx_d;
      aw_oor_q  <= aw_oor_d;
      w_full_q  <= w_full_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      wr_cnt_q  <= wr_cnt_d;
      regs_q    <= regs_d;
    end
  end

  // read-side state: FSM, held response data, accept counter
  always_ff @(posedge ALCLK) begin
    if (ARESET) begin
      rd_state_q <= RD_IDLE;
      rdata_q    <= '0;
      rd_cnt_q   <= '0;
    end else begin
      rd_state_q <= rd_state_d;
      rdata_q    <= rdata_d;
      rd_cnt_q   <= rd_cnt_d;
    end
  end

endmodule
